// File: rtl/fifo_rd_streamer.sv
// Drains a synchronous FIFO with one-cycle read latency into a valid/ready stream framed every PKT_LEN beats.
// Optional per-beat/per-packet counters are enabled with FIFO_RD_STREAMER_STATS_EN.
module fifo_rd_streamer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned PKT_LEN    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy
`ifdef FIFO_RD_STREAMER_STATS_EN
  ,
  output logic [15:0]           beat_total,
  output logic [15:0]           pkt_total
`endif
);

  localparam int unsigned   BW        = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  state_e                  state_q, state_d;
  logic [1:0]              occ_q, occ_d;
  logic                    inflight_q;
  logic                    wr_ptr_q, rd_ptr_q;
  logic [DATA_WIDTH-1:0]   mem_q [2];
  logic [BW-1:0]           beat_q, beat_d;
  logic                    push, pop;
  logic [2:0]              credit;

  assign push = inflight_q;
  assign pop  = m_valid & m_ready;

  // Slots already claimed (held + in flight), net of the word leaving this cycle.
  assign credit     = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign fifo_rd_en = enable & ~fifo_empty & ~rst & (credit < 3'd2);

  assign m_valid = (occ_q != 2'd0);
  assign m_data  = mem_q[rd_ptr_q];
  assign m_last  = m_valid & (beat_q == LAST_BEAT);
  assign busy    = (state_q != IDLE);

  always_comb begin
    occ_d = occ_q;
    if (push && !pop) begin
      occ_d = occ_q + 2'd1;
    end else if (pop && !push) begin
      occ_d = occ_q - 2'd1;
    end
  end

  always_comb begin
    beat_d = beat_q;
    if (pop) begin
      beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (enable) state_d = RUN;
      end
      RUN: begin
        if (!enable) state_d = ((occ_q != 2'd0) || inflight_q) ? DRAIN : IDLE;
      end
      DRAIN: begin
        if (enable) begin
          state_d = RUN;
        end else if ((occ_q == 2'd0) && !inflight_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      occ_q      <= '0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      beat_q     <= '0;
    end else begin
      state_q    <= state_d;
      occ_q      <= occ_d;
      inflight_q <= fifo_rd_en;
      beat_q     <= beat_d;
      if (push) begin
        mem_q[wr_ptr_q] <= fifo_data_out;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

`ifdef FIFO_RD_STREAMER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_total <= '0;
      pkt_total  <= '0;
    end else if (pop) begin
      beat_total <= beat_total + 16'd1;
      if (m_last) pkt_total <= pkt_total + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Randomized bench for fifo_rd_streamer: a queue-based FIFO and stream scoreboard predict every output.
// Build with FIFO_RD_STREAMER_STATS_EN defined to also check the beat/packet counters.
module tb_fifo_rd_streamer;

  localparam int PKT_LEN = 4;

  logic        clk = 1'b0;
  logic        rst, enable, fifo_empty, force_empty, m_ready;
  logic [15:0] fifo_dout;
  logic        fifo_rd_en, m_valid, m_last, busy;
  logic [15:0] m_data;
`ifdef FIFO_RD_STREAMER_STATS_EN
  logic [15:0] beat_total, pkt_total;
`endif

  logic [15:0] fifo_q[$];
  logic [15:0] buf_q[$];
  logic        infl;
  logic [15:0] infl_word;
  int          beat, st, hs, cyc, last_hs_cyc;
  logic [15:0] exp_bt, exp_pt;
  int          vec, errs;

  fifo_rd_streamer #(.DATA_WIDTH(16), .PKT_LEN(PKT_LEN)) dut (
    .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_data_out(fifo_dout), .fifo_rd_en(fifo_rd_en), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .busy(busy)
`ifdef FIFO_RD_STREAMER_STATS_EN
    , .beat_total(beat_total), .pkt_total(pkt_total)
`endif
  );

  always #5 clk = ~clk;

  // One clock: check outputs mid-cycle against the model, then advance model and FIFO past the edge.
  task automatic tick();
    logic ev, ep, er, el, eb, rd;
    logic [15:0] w;
    int used;
    fifo_empty = force_empty || (fifo_q.size() == 0);
    @(negedge clk);
    ev   = (buf_q.size() != 0);
    ep   = ev && m_ready;
    used = buf_q.size() + (infl ? 1 : 0) - (ep ? 1 : 0);
    er   = !rst && enable && !fifo_empty && (used < 2);
    el   = ev && (beat == PKT_LEN - 1);
    eb   = (st != 0);
    vec += 4;
    if (m_valid !== ev) begin errs++; $display("FAIL m_valid cyc=%0d got=%b exp=%b", cyc, m_valid, ev); end
    if (fifo_rd_en !== er) begin errs++; $display("FAIL fifo_rd_en cyc=%0d got=%b exp=%b", cyc, fifo_rd_en, er); end
    if (m_last !== el) begin errs++; $display("FAIL m_last cyc=%0d got=%b exp=%b", cyc, m_last, el); end
    if (busy !== eb) begin errs++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, eb); end
    if (ev) begin
      vec++;
      if (m_data !== buf_q[0]) begin errs++; $display("FAIL m_data cyc=%0d got=%h exp=%h", cyc, m_data, buf_q[0]); end
    end
`ifdef FIFO_RD_STREAMER_STATS_EN
    vec += 2;
    if (beat_total !== exp_bt) begin errs++; $display("FAIL beat_total cyc=%0d got=%0d exp=%0d", cyc, beat_total, exp_bt); end
    if (pkt_total !== exp_pt) begin errs++; $display("FAIL pkt_total cyc=%0d got=%0d exp=%0d", cyc, pkt_total, exp_pt); end
`endif
    rd = (fifo_rd_en === 1'b1);
    w  = 16'h0;
    if (rd && fifo_q.size() != 0) w = fifo_q.pop_front();
    @(posedge clk);
    #1;
    cyc++;
    fifo_dout = rd ? w : 16'($urandom);
    if (rst) begin
      buf_q.delete();
      infl = 1'b0; beat = 0; st = 0; exp_bt = '0; exp_pt = '0;
    end else begin
      case (st)
        0: if (enable) st = 1;
        1: if (!enable) st = (ev || infl) ? 2 : 0;
        default: if (enable) st = 1; else if (!ev && !infl) st = 0;
      endcase
      if (ep) begin
        buf_q.delete(0);
        hs++;
        last_hs_cyc = cyc;
        exp_bt++;
        if (el) exp_pt++;
        beat = (beat == PKT_LEN - 1) ? 0 : beat + 1;
      end
      if (infl) buf_q.push_back(infl_word);
      infl      = rd;
      infl_word = w;
    end
  endtask

  task automatic drain_idle(input string name);
    int n = 0;
    enable = 1'b0;
    while ((st != 0 || buf_q.size() != 0 || infl) && n < 40) begin
      m_ready = 1'b1;
      tick();
      n++;
    end
    vec++;
    if (busy !== 1'b0 || st != 0) begin
      errs++; $display("FAIL %s_drain busy=%b model_state=%0d exp_idle", name, busy, st);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; force_empty = 1'b0; m_ready = 1'b0; fifo_dout = '0;
    fifo_q.push_back(16'hAAAA); fifo_q.push_back(16'h5555);
    fifo_empty = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vec += 5;
    if (fifo_rd_en !== 1'b0) begin errs++; $display("FAIL reset_rd_en got=%b exp=0", fifo_rd_en); end
    if (m_valid !== 1'b0) begin errs++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
    if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (m_data !== 16'h0) begin errs++; $display("FAIL reset_m_data got=%h exp=0000", m_data); end
    if (m_last !== 1'b0) begin errs++; $display("FAIL reset_m_last got=%b exp=0", m_last); end
`ifdef FIFO_RD_STREAMER_STATS_EN
    vec += 2;
    if (beat_total !== 16'd0) begin errs++; $display("FAIL reset_beat_total got=%0d exp=0", beat_total); end
    if (pkt_total !== 16'd0) begin errs++; $display("FAIL reset_pkt_total got=%0d exp=0", pkt_total); end
`endif
    @(posedge clk);
    #1;
    buf_q.delete(); fifo_q.delete();
    infl = 1'b0; beat = 0; st = 0; exp_bt = '0; exp_pt = '0;
    rst = 1'b0; enable = 1'b0;
  endtask

  task automatic test_streaming();
    int h0 = hs, first = -1, n = 0;
    for (int i = 1; i <= 8; i++) fifo_q.push_back(16'(i));
    enable = 1'b1; m_ready = 1'b1;
    while (hs - h0 < 8 && n < 40) begin
      int hb = hs;
      tick();
      if (hs != hb && first < 0) first = last_hs_cyc;
      n++;
    end
    vec += 2;
    if (hs - h0 != 8) begin errs++; $display("FAIL stream_count got=%0d exp=8", hs - h0); end
    if (last_hs_cyc - first != 7) begin errs++; $display("FAIL stream_bubbles span=%0d exp=7", last_hs_cyc - first); end
`ifdef FIFO_RD_STREAMER_STATS_EN
    vec += 2;
    if (beat_total !== 16'd8) begin errs++; $display("FAIL stats_beats got=%0d exp=8", beat_total); end
    if (pkt_total !== 16'd2) begin errs++; $display("FAIL stats_pkts got=%0d exp=2", pkt_total); end
`endif
    drain_idle("stream");
  endtask

  task automatic test_backpressure();
    int h0 = hs, n = 0;
    for (int i = 0; i < 12; i++) fifo_q.push_back(16'($urandom));
    enable = 1'b1; m_ready = 1'b1;
    repeat (6) tick();
    m_ready = 1'b0;
    repeat (5) tick();
    vec += 2;
    if (fifo_rd_en !== 1'b0) begin errs++; $display("FAIL bp_full_rd_en got=%b exp=0", fifo_rd_en); end
    if (m_valid !== 1'b1) begin errs++; $display("FAIL bp_full_valid got=%b exp=1", m_valid); end
    m_ready = 1'b1;
    while (hs - h0 < 12 && n < 40) begin tick(); n++; end
    vec++;
    if (hs - h0 != 12) begin errs++; $display("FAIL bp_count got=%0d exp=12", hs - h0); end
    drain_idle("bp");
  endtask

  task automatic test_enable_drop();
    int h0 = hs, n = 0;
    for (int i = 0; i < 6; i++) fifo_q.push_back(16'($urandom));
    enable = 1'b1; m_ready = 1'b0;
    tick();
    enable = 1'b0;
    while ((st != 0 || busy !== 1'b0) && n < 40) begin
      m_ready = 1'($urandom);
      tick();
      n++;
    end
    vec += 2;
    if (hs - h0 != 1) begin errs++; $display("FAIL drop_count got=%0d exp=1", hs - h0); end
    if (busy !== 1'b0) begin errs++; $display("FAIL drop_busy got=%b exp=0", busy); end
    fifo_q.delete();
  endtask

  task automatic test_empty_edge();
    int h0 = hs, n = 0;
    enable = 1'b1; m_ready = 1'b1; force_empty = 1'b0;
    repeat (10) tick();
    fifo_q.push_back(16'hBEEF);
    repeat (10) tick();
    vec++;
    if (hs - h0 != 1) begin errs++; $display("FAIL empty_single got=%0d exp=1", hs - h0); end
    h0 = hs;
    for (int i = 0; i < 6; i++) fifo_q.push_back(16'($urandom));
    for (int i = 0; i < 30; i++) begin
      force_empty = ~force_empty;
      m_ready = 1'($urandom);
      tick();
    end
    force_empty = 1'b0;
    while ((fifo_q.size() != 0 || buf_q.size() != 0 || infl) && n < 40) begin
      m_ready = 1'b1; tick(); n++;
    end
    vec++;
    if (hs - h0 != 6) begin errs++; $display("FAIL toggle_count got=%0d exp=6", hs - h0); end
    drain_idle("empty");
  endtask

  task automatic test_reset_mid();
    int h0 = hs, n = 0;
    for (int i = 0; i < 8; i++) fifo_q.push_back(16'($urandom));
    enable = 1'b1; m_ready = 1'b1;
    while (hs - h0 < 2 && n < 20) begin tick(); n++; end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vec += 2;
    if (m_valid !== 1'b0) begin errs++; $display("FAIL rstmid_valid got=%b exp=0", m_valid); end
    if (busy !== 1'b0) begin errs++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    n = 0;
    while ((fifo_q.size() != 0 || buf_q.size() != 0 || infl) && n < 40) begin tick(); n++; end
    drain_idle("rstmid");
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst         = ($urandom_range(49) == 0);
      enable      = ($urandom_range(3) != 0);
      m_ready     = ($urandom_range(2) != 0);
      force_empty = ($urandom_range(4) == 0);
      if (fifo_q.size() < 6 && $urandom_range(1) == 1) fifo_q.push_back(16'($urandom));
      tick();
    end
    rst = 1'b0; force_empty = 1'b0;
    drain_idle("random");
    fifo_q.delete();
  endtask

`ifdef FIFO_RD_STREAMER_STATS_EN
  task automatic test_stats();
    int h0, n = 0;
    rst = 1'b1; tick(); rst = 1'b0;
    h0 = hs;
    for (int i = 0; i < 8; i++) fifo_q.push_back(16'($urandom));
    enable = 1'b1; m_ready = 1'b1;
    while (hs - h0 < 8 && n < 40) begin tick(); n++; end
    vec += 2;
    if (beat_total !== 16'd8) begin errs++; $display("FAIL stats_beat8 got=%0d exp=8", beat_total); end
    if (pkt_total !== 16'd2) begin errs++; $display("FAIL stats_pkt2 got=%0d exp=2", pkt_total); end
    enable = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
    vec += 2;
    if (beat_total !== 16'd0) begin errs++; $display("FAIL stats_clr_beat got=%0d exp=0", beat_total); end
    if (pkt_total !== 16'd0) begin errs++; $display("FAIL stats_clr_pkt got=%0d exp=0", pkt_total); end
  endtask
`endif

  initial begin
    vec = 0; errs = 0; hs = 0; cyc = 0; last_hs_cyc = 0;
    beat = 0; st = 0; infl = 1'b0; infl_word = '0; exp_bt = '0; exp_pt = '0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_enable_drop();
    test_empty_edge();
    test_reset_mid();
    test_random();
`ifdef FIFO_RD_STREAMER_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1);
  end

endmodule
